// File: rtl/pb_debounce_pkg.sv
// pb_debounce_pkg
//   Shared definitions for the multi-channel push-button conditioner:
//   counter-width helpers and default timing constants.
package pb_debounce_pkg;

  localparam int DEF_TICK_DIV     = 4;
  localparam int DEF_STABLE_COUNT = 4;

  // Ceiling log2 of value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

  // Bits needed to hold 0..max_value, never less than one bit.
  function automatic int cnt_width(input int max_value);
    int width;
    width = clog2(max_value + 1);
    if (width < 1) begin
      width = 1;
    end else begin
      width = width;
    end
    return width;
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// pb_debounce_chan
//   One debounced channel: two-flop synchroniser, stability counter that
//   accepts a new level after STABLE_COUNT consecutive differing ticks,
//   rise/fall pulse registers and an optional long-press hold counter.
// Ports:
//   Clk      system clock
//   Reset    asynchronous active-high reset
//   tick     sample-tick clock enable from the shared prescaler
//   pb_in    raw asynchronous button input
//   pb_out   debounced level
//   pb_rise  1-cycle pulse on accepted 0->1
//   pb_fall  1-cycle pulse on accepted 1->0
//   pb_long  1-cycle pulse when a high level has lasted LONG_TICKS ticks
module pb_debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int LONG_TICKS   = 0,
  parameter int IDLE_LEVEL   = 0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic pb_in,
  output logic pb_out,
  output logic pb_rise,
  output logic pb_fall,
  output logic pb_long
);

  localparam int CW = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_COUNT - 1);
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0) ? 1'b1 : 1'b0;

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_r <= IDLE_BIT;
      sync2_r <= IDLE_BIT;
    end else begin
      sync1_r <= pb_in;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter and accepted level; edge pulses default low so they
  // last exactly one clock even when ticks are sparse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r   <= {CW{1'b0}};
      pb_out  <= IDLE_BIT;
      pb_rise <= 1'b0;
      pb_fall <= 1'b0;
    end else begin
      pb_rise <= 1'b0;
      pb_fall <= 1'b0;
      if (tick) begin
        if (sync2_r == pb_out) begin
          cnt_r <= {CW{1'b0}};
        end else if (cnt_r == ST_LAST) begin
          pb_out  <= sync2_r;
          cnt_r   <= {CW{1'b0}};
          pb_rise <= sync2_r;
          pb_fall <= ~sync2_r;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  generate
    if (LONG_TICKS > 0) begin : g_long
      localparam int HW = cnt_width(LONG_TICKS);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
      localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

      logic [HW-1:0] hold_r;

      // Hold counter saturates at LONG_TICKS so the pulse fires once per
      // press; only a release (pb_out low) re-arms it.
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          hold_r  <= {HW{1'b0}};
          pb_long <= 1'b0;
        end else begin
          pb_long <= 1'b0;
          if (!pb_out) begin
            hold_r <= {HW{1'b0}};
          end else if (tick && (hold_r != HOLD_MAX)) begin
            hold_r  <= hold_r + HW'(1);
            pb_long <= (hold_r == HOLD_LAST);
          end else begin
            hold_r <= hold_r;
          end
        end
      end
    end else begin : g_no_long
      assign pb_long = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pb_debounce_multi.sv
// pb_debounce_multi
//   Multi-channel push-button conditioner. A shared prescaler produces a
//   one-clock sample tick every TICK_DIV clocks; each channel is debounced
//   independently against that tick.
// Ports:
//   Clk      system clock
//   Reset    asynchronous active-high reset
//   pb_in    raw button inputs, one bit per channel
//   pb_out   debounced levels
//   pb_rise  1-cycle pulses on accepted 0->1
//   pb_fall  1-cycle pulses on accepted 1->0
//   pb_long  1-cycle long-press pulses (tied low when LONG_TICKS = 0)
module pb_debounce_multi
  import pb_debounce_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int LONG_TICKS   = 0,
  parameter int IDLE_LEVEL   = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_out,
  output logic [CHANNELS-1:0] pb_rise,
  output logic [CHANNELS-1:0] pb_fall,
  output logic [CHANNELS-1:0] pb_long
);

  localparam int PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_cnt_r;
  logic          tick_s;

  // Tick is a clock enable, high during the last count of each period;
  // with TICK_DIV = 1 the counter sits at zero and tick stays high.
  assign tick_s = (ps_cnt_r == PS_LAST);

  // Sample-tick prescaler shared by all channels.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ps_cnt_r <= {PW{1'b0}};
    end else if (tick_s) begin
      ps_cnt_r <= {PW{1'b0}};
    end else begin
      ps_cnt_r <= ps_cnt_r + PW'(1);
    end
  end

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
      pb_debounce_chan #(
        .STABLE_COUNT (STABLE_COUNT),
        .LONG_TICKS   (LONG_TICKS),
        .IDLE_LEVEL   (IDLE_LEVEL)
      ) u_chan (
        .Clk     (Clk),
        .Reset   (Reset),
        .tick    (tick_s),
        .pb_in   (pb_in[ch]),
        .pb_out  (pb_out[ch]),
        .pb_rise (pb_rise[ch]),
        .pb_fall (pb_fall[ch]),
        .pb_long (pb_long[ch])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Bench for pb_debounce_multi: three builds (fast tick with long press,
// divided tick, idle-high buttons) run side by side against a behavioural
// model, plus directed checks for the timing corner cases.
module tb_pb_debounce_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_a = 4'h0, in_b = 4'h0, in_c = 4'h0;
  logic [3:0] out_a, rise_a, fall_a, long_a;
  logic [3:0] out_b, rise_b, fall_b, long_b;
  logic [3:0] out_c, rise_c, fall_c, long_c;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  pb_debounce_multi #(.CHANNELS(4), .TICK_DIV(1), .STABLE_COUNT(4), .LONG_TICKS(5), .IDLE_LEVEL(0)) dut_a (
    .Clk(clk), .Reset(rst), .pb_in(in_a), .pb_out(out_a), .pb_rise(rise_a), .pb_fall(fall_a), .pb_long(long_a));
  pb_debounce_multi #(.CHANNELS(4), .TICK_DIV(4), .STABLE_COUNT(3), .LONG_TICKS(0), .IDLE_LEVEL(0)) dut_b (
    .Clk(clk), .Reset(rst), .pb_in(in_b), .pb_out(out_b), .pb_rise(rise_b), .pb_fall(fall_b), .pb_long(long_b));
  pb_debounce_multi #(.CHANNELS(4), .TICK_DIV(2), .STABLE_COUNT(2), .LONG_TICKS(0), .IDLE_LEVEL(1)) dut_c (
    .Clk(clk), .Reset(rst), .pb_in(in_c), .pb_out(out_c), .pb_rise(rise_c), .pb_fall(fall_c), .pb_long(long_c));

  // Behavioural model: per build, parameters and per-channel state.
  int         TD [3] = '{1, 4, 2};
  int         SC [3] = '{4, 3, 2};
  int         LT [3] = '{5, 0, 0};
  logic [3:0] IDL[3] = '{4'h0, 4'h0, 4'hF};

  logic [3:0] m_out[3], m_d1[3], m_d2[3], m_rise[3], m_fall[3], m_long[3];
  int         m_run[3][4];
  int         m_held[3][4];
  int         m_n;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_out[k] = IDL[k]; m_d1[k] = IDL[k]; m_d2[k] = IDL[k];
      m_rise[k] = 4'h0; m_fall[k] = 4'h0; m_long[k] = 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        m_run[k][ch] = 0; m_held[k][ch] = 0;
      end
    end
    m_n = 0;
  endtask

  // One clock edge of the model: input seen two edges late, accepted after
  // SC consecutive ticks of disagreement, hold counts ticks of high level.
  task automatic model_edge();
    logic [3:0] pin[3];
    logic o;
    logic tk;
    pin[0] = in_a; pin[1] = in_b; pin[2] = in_c;
    if (rst) begin
      model_reset();
    end else begin
      m_n++;
      for (int k = 0; k < 3; k++) begin
        tk = ((m_n % TD[k]) == 0);
        m_rise[k] = 4'h0; m_fall[k] = 4'h0; m_long[k] = 4'h0;
        for (int ch = 0; ch < 4; ch++) begin
          o = m_out[k][ch];
          if (tk) begin
            if (m_d2[k][ch] != o) begin
              m_run[k][ch]++;
              if (m_run[k][ch] == SC[k]) begin
                m_out[k][ch] = m_d2[k][ch];
                m_run[k][ch] = 0;
                if (m_d2[k][ch]) m_rise[k][ch] = 1'b1;
                else             m_fall[k][ch] = 1'b1;
              end
            end else begin
              m_run[k][ch] = 0;
            end
          end
          if (!o) begin
            m_held[k][ch] = 0;
          end else if (tk && LT[k] > 0 && m_held[k][ch] < LT[k]) begin
            m_held[k][ch]++;
            if (m_held[k][ch] == LT[k]) m_long[k][ch] = 1'b1;
          end
        end
        m_d2[k] = m_d1[k];
        m_d1[k] = pin[k];
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("a.out",  out_a,  m_out[0]);  check("a.rise", rise_a, m_rise[0]);
    check("a.fall", fall_a, m_fall[0]); check("a.long", long_a, m_long[0]);
    check("b.out",  out_b,  m_out[1]);  check("b.rise", rise_b, m_rise[1]);
    check("b.fall", fall_b, m_fall[1]); check("b.long", long_b, m_long[1]);
    check("c.out",  out_c,  m_out[2]);  check("c.rise", rise_c, m_rise[2]);
    check("c.fall", fall_c, m_fall[2]); check("c.long", long_c, m_long[2]);
  endtask

  // Advance one clock, update model, compare just after the edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
    compare_all();
  endtask

  int bounce_seq[16] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int seen, bad, lat, t_rise, t_long, nlong, idx;
    logic found;

    // Reset with idle-high build's buttons already pressed (low).
    rst = 1'b1; in_a = 4'h0; in_b = 4'h0; in_c = 4'h0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;

    // Clean press on A ch0, B ch2 pressed, C inputs held low.
    in_a = 4'b0001; in_b = 4'b0100;
    seen = 0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      if (e == 1) check("c.no_pulse_at_release", rise_c | fall_c, 4'h0);
      if (e == 5) check("a.out_before_edge6", out_a, 4'b0000);
      if (e == 6) begin
        check("a.out_at_edge6", out_a, 4'b0001);
        check("a.rise_at_edge6", rise_a, 4'b0001);
      end
      if (e == 7) check("a.rise_cleared_edge7", rise_a, 4'b0000);
      if (fall_c == 4'hF) seen++;
    end
    check_int("c.fall_once", seen, 1);

    // Bounce on A ch1: high 3, low 1, high 2, then low.
    bad = 0;
    foreach (bounce_seq[i]) begin
      in_a[1] = (bounce_seq[i] != 0);
      cyc();
      if (out_a[1] | rise_a[1] | fall_a[1]) bad++;
    end
    check_int("a.bounce_rejected", bad, 0);

    // Release on B ch2 and measure latency.
    check("b.ch2_accepted", out_b, 4'b0100);
    in_b = 4'h0; lat = 0; found = 1'b0;
    while (!found && lat < 40) begin
      cyc(); lat++;
      if (fall_b[2]) found = 1'b1;
    end
    check_int("b.fall_seen", int'(found), 1);
    check_int("b.fall_latency_in_range", (lat >= 11 && lat <= 14) ? 1 : 0, 1);
    cyc();
    check("b.fall_one_cycle", fall_b, 4'h0);

    // Long press on A ch3.
    in_a[3] = 1'b1; t_rise = -1; t_long = -1; nlong = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (rise_a[3]) t_rise = cyc_no;
      if (long_a[3]) begin nlong++; if (t_long < 0) t_long = cyc_no; end
    end
    check_int("a.long_delay", t_long - t_rise, 5);
    check_int("a.long_once", nlong, 1);
    in_a[3] = 1'b0;
    repeat (12) cyc();
    in_a[3] = 1'b1; nlong = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (long_a[3]) nlong++;
    end
    check_int("a.long_rearm", nlong, 1);

    // Simultaneous press on all A channels.
    in_a = 4'h0;
    repeat (12) cyc();
    in_a = 4'hF; found = 1'b0; lat = 0;
    while (!found && lat < 20) begin
      cyc(); lat++;
      if (rise_a != 4'h0) found = 1'b1;
    end
    check("a.rise_all", rise_a, 4'hF);

    // Reset mid-operation: A held, B mid-count.
    repeat (6) cyc();
    in_b = 4'hF;
    repeat (3) cyc();
    rst = 1'b1;
    model_reset();
    #1;
    check("a.reset_out", out_a, 4'h0);
    check("a.reset_pulses", rise_a | fall_a | long_a, 4'h0);
    check("b.reset_out", out_b, 4'h0);
    repeat (2) cyc();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check_int("b.first_tick_after_reset", int'(dut_b.tick_s), (i == 4) ? 1 : 0);
      cyc();
    end

    // Randomised phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin idx = int'($urandom_range(0, 3)); in_a[idx] = ~in_a[idx]; end
      if ($urandom_range(0, 9) == 0) begin idx = int'($urandom_range(0, 3)); in_b[idx] = ~in_b[idx]; end
      if ($urandom_range(0, 6) == 0) begin idx = int'($urandom_range(0, 3)); in_c[idx] = ~in_c[idx]; end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
